atmega_btn_ctrl: RTL and testbench

Parametrised N-channel button/input controller on the 8-bit IO bus of the atmega32u4_arduboy core, replacing the single-flop button sampling feeding PORTA. It provides:
- 2-FF synchronisation, per-channel tick-based debounce and polarity normalisation.
- Edge-detected event flags with mask and an interrupt request.
- An optional hold-to-repeat generator.

Software sees debounced state and flags through memory-mapped registers.

---
 rtl/atmega_btn_ctrl_pkg.sv | 46 ++++
 rtl/atmega_btn_ctrl_if.sv | 15 +
 rtl/atmega_btn_ctrl_debounce.sv | 101 ++++++++++
 rtl/atmega_btn_ctrl.sv | 130 +++++++++++++
 tb/tb_atmega_btn_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atmega_btn_ctrl_pkg.sv
// Shared definitions for the button controller: default IO register
// addresses, the register-select type and the per-channel event record.
// IFR/IMSK/RISE/FALL/PIN share one layout: bit n belongs to channel n.
// Optional feature macro: BTN_CTRL_AUTOREPEAT_EN (hold-to-repeat).
package atmega_btn_ctrl_pkg;

   localparam logic [7:0] PIN_ADDR_DEF  = 8'h23;
   localparam logic [7:0] IFR_ADDR_DEF  = 8'h24;
   localparam logic [7:0] IMSK_ADDR_DEF = 8'h25;
   localparam logic [7:0] RISE_ADDR_DEF = 8'h26;
   localparam logic [7:0] FALL_ADDR_DEF = 8'h27;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_PIN,
      SEL_IFR,
      SEL_IMSK,
      SEL_RISE,
      SEL_FALL
   } reg_sel_e;

   // Single-cycle event pulses produced by one debounce channel.
   typedef struct packed {
      logic rise;   // stable went 0 -> 1 on this edge
      logic fall;   // stable went 1 -> 0 on this edge
      logic rep;    // hold-to-repeat boundary reached on this edge
   } ch_evt_t;

   // Map an IO address onto one of the controller's registers.
   function automatic reg_sel_e decode_addr(
      input logic [7:0] addr,
      input logic [7:0] pin_a,
      input logic [7:0] ifr_a,
      input logic [7:0] imsk_a,
      input logic [7:0] rise_a,
      input logic [7:0] fall_a
   );
      if (addr == pin_a)       return SEL_PIN;
      else if (addr == ifr_a)  return SEL_IFR;
      else if (addr == imsk_a) return SEL_IMSK;
      else if (addr == rise_a) return SEL_RISE;
      else if (addr == fall_a) return SEL_FALL;
      else                     return SEL_NONE;
   endfunction

endpackage

// File: rtl/atmega_btn_ctrl_if.sv
// IO bus bundle between the AVR core and the button controller.
// The core is the master; the controller is the slave and returns read
// data that is zero whenever it is not selected.
interface atmega_btn_ctrl_if;

   logic [7:0] addr;
   logic       wr;
   logic       rd;
   logic [7:0] bus_in;
   logic [7:0] bus_out;

   modport master (output addr, wr, rd, bus_in, input bus_out);
   modport slave  (input addr, wr, rd, bus_in, output bus_out);

endinterface

// File: rtl/atmega_btn_ctrl_debounce.sv
// One button channel: 2-FF synchroniser, polarity normalisation, tick-based
// debounce counter, edge pulses and (with BTN_CTRL_AUTOREPEAT_EN) the
// hold-to-repeat counter. Instantiated once per channel by atmega_btn_ctrl.
module btn_debounce_ch
   import atmega_btn_ctrl_pkg::*;
#(
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter int DB_SAMPLES   = 8
`ifdef BTN_CTRL_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY = 400,
   parameter int REPEAT_RATE  = 100
`endif
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    btn,
   input  logic    tick,
`ifdef BTN_CTRL_AUTOREPEAT_EN
   input  logic    rise_en,
`endif
   output logic    stable,
   output ch_evt_t evt
);

   localparam logic [3:0] DC_LAST = 4'(DB_SAMPLES - 1);

   logic       sync1;
   logic       sync2;
   logic       s;
   logic       stable_q;
   logic [3:0] dc;
   logic       accept;

   // Logical level: 1 means pressed regardless of pin polarity.
   assign s      = sync2 ^ ACTIVE_LOW;
   assign accept = (s != stable_q) && tick && (dc == DC_LAST);

   // Two-flop synchroniser; resets to the released pin level.
   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignment so sync2 samples the
      // old sync1 value; a blocking '=' here would collapse the chain.
      if (!rst_n) begin
         sync1 <= ACTIVE_LOW;
         sync2 <= ACTIVE_LOW;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Debounce: count ticks while s disagrees, accept after DB_SAMPLES ticks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_q <= 1'b0;
         dc       <= '0;
      end else if (s == stable_q) begin
         dc <= '0;
      end else if (tick) begin
         if (dc == DC_LAST) begin
            stable_q <= s;
            dc       <= '0;
         end else begin
            dc <= dc + 4'd1;
         end
      end
   end

   assign stable   = stable_q;
   assign evt.rise = accept & s;
   assign evt.fall = accept & ~s;

`ifdef BTN_CTRL_AUTOREPEAT_EN
   localparam logic [16:0] REP_FIRST = 17'(REPEAT_DELAY);
   localparam logic [16:0] REP_WRAP  = 17'(REPEAT_DELAY + REPEAT_RATE);

   logic [15:0] rc;
   logic [16:0] rc_inc;
   logic        rep_count;
   logic        rep_wrap;

   assign rc_inc    = {1'b0, rc} + 17'd1;
   assign rep_count = stable_q & rise_en & tick;
   assign rep_wrap  = (rc_inc == REP_WRAP);

   // Hold-time counter: cleared when released, restarts at the delay point
   // each time a rate period completes, and never wraps past all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n || !stable_q) begin
         rc <= '0;
      end else if (rep_count && (rc != 16'hFFFF)) begin
         rc <= rep_wrap ? REP_FIRST[15:0] : rc_inc[15:0];
      end
   end

   assign evt.rep = rep_count & ((rc_inc == REP_FIRST) | rep_wrap);
`else
   assign evt.rep = 1'b0;
`endif

endmodule

// File: rtl/atmega_btn_ctrl.sv
// N-channel button controller on the AVR 8-bit IO bus: shared debounce
// prescaler, per-channel debounce instances and the PIN/IFR/IMSK/RISE/FALL
// register file with interrupt request.
// Optional feature macro: BTN_CTRL_AUTOREPEAT_EN (hold-to-repeat flags).
module atmega_btn_ctrl
   import atmega_btn_ctrl_pkg::*;
#(
   parameter int         CHANNELS        = 8,
   parameter int         TICK_DIV        = 16000,
   parameter int         DB_SAMPLES      = 8,
   parameter logic [7:0] ACTIVE_LOW_MASK = 8'hFF,
   parameter int         REPEAT_DELAY    = 400,
   parameter int         REPEAT_RATE     = 100,
   parameter logic [7:0] PIN_ADDR        = PIN_ADDR_DEF,
   parameter logic [7:0] IFR_ADDR        = IFR_ADDR_DEF,
   parameter logic [7:0] IMSK_ADDR       = IMSK_ADDR_DEF,
   parameter logic [7:0] RISE_ADDR       = RISE_ADDR_DEF,
   parameter logic [7:0] FALL_ADDR       = FALL_ADDR_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   atmega_btn_ctrl_if.slave     bus,
   input  logic [CHANNELS-1:0]  btn_in,
   output logic [CHANNELS-1:0]  btn_state,
   output logic                 intr,
   input  logic                 int_rst
);

   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]       presc;
   logic                tick;
   logic [CHANNELS-1:0] stable;
   ch_evt_t             evt [CHANNELS];

   logic [CHANNELS-1:0] ifr;
   logic [CHANNELS-1:0] imsk;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] ifr_set;
   logic [CHANNELS-1:0] ifr_next;
   logic [CHANNELS-1:0] wdata;
   reg_sel_e            sel;
   logic [7:0]          rdata;

   assign tick = (presc == PRESC_LAST);

   // Free-running prescaler producing one tick per TICK_DIV clocks.
   always_ff @(posedge clk) begin
      if (!rst_n || tick) presc <= '0;
      else                presc <= presc + PW'(1);
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      btn_debounce_ch #(
         .ACTIVE_LOW   (ACTIVE_LOW_MASK[i]),
         .DB_SAMPLES   (DB_SAMPLES)
`ifdef BTN_CTRL_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
`endif
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn     (btn_in[i]),
         .tick    (tick),
`ifdef BTN_CTRL_AUTOREPEAT_EN
         .rise_en (rise[i]),
`endif
         .stable  (stable[i]),
         .evt     (evt[i])
      );
   end

   assign sel   = decode_addr(bus.addr, PIN_ADDR, IFR_ADDR, IMSK_ADDR,
                              RISE_ADDR, FALL_ADDR);
   assign wdata = bus.bus_in[CHANNELS-1:0];

   // Next IFR: clear by W1C and acknowledge, then OR in this edge's events.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      ifr_set  = '0;
      ifr_next = ifr;
      for (int i = 0; i < CHANNELS; i++) begin
         ifr_set[i] = (evt[i].rise & rise[i]) | (evt[i].fall & fall[i]) | evt[i].rep;
      end
      if (bus.wr && (sel == SEL_IFR)) ifr_next = ifr_next & ~wdata;
      if (int_rst)                    ifr_next = ifr_next & ~imsk;
      // Set is applied last so a same-edge hardware event always survives.
      ifr_next = ifr_next | ifr_set;
   end

   // Register file; PIN is read-only so writes to it fall through.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ifr  <= '0;
         imsk <= '0;
         rise <= '1;
         fall <= '0;
      end else begin
         ifr <= ifr_next;
         if (bus.wr && (sel == SEL_IMSK)) imsk <= wdata;
         if (bus.wr && (sel == SEL_RISE)) rise <= wdata;
         if (bus.wr && (sel == SEL_FALL)) fall <= wdata;
      end
   end

   // Zero-latency read mux; drives 0 unless a mapped register is read.
   always_comb begin
      rdata = '0;
      if (bus.rd) begin
         unique case (sel)
            SEL_PIN:  rdata[CHANNELS-1:0] = stable;
            SEL_IFR:  rdata[CHANNELS-1:0] = ifr;
            SEL_IMSK: rdata[CHANNELS-1:0] = imsk;
            SEL_RISE: rdata[CHANNELS-1:0] = rise;
            SEL_FALL: rdata[CHANNELS-1:0] = fall;
            default:  rdata = '0;
         endcase
      end
   end

   assign bus.bus_out = rdata;
   assign btn_state   = stable;
   assign intr        = |(ifr & imsk);

endmodule

// File: tb/tb_atmega_btn_ctrl.sv
// Self-checking bench for atmega_btn_ctrl with TICK_DIV=4, DB_SAMPLES=3,
// REPEAT_DELAY=4, REPEAT_RATE=2. A reference model expresses debounce as
// "tick count inside the current disagreement window" and tracks the
// register file; directed scenarios check the documented latencies and
// priorities, then a randomized run compares against the model each cycle.
// Expectations follow BTN_CTRL_AUTOREPEAT_EN when it is defined.
module tb_atmega_btn_ctrl;

   localparam int         T      = 4;
   localparam int         DB     = 3;
   localparam int         D      = 4;
   localparam int         R      = 2;
   localparam logic [7:0] ALM    = 8'hFF;
   localparam logic [7:0] A_PIN  = 8'h23;
   localparam logic [7:0] A_IFR  = 8'h24;
   localparam logic [7:0] A_IMSK = 8'h25;
   localparam logic [7:0] A_RISE = 8'h26;
   localparam logic [7:0] A_FALL = 8'h27;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] btn_in;
   logic [7:0] btn_state;
   logic       intr;
   logic       int_rst;

   int n_cmp = 0;
   int n_bad = 0;

   atmega_btn_ctrl_if bus ();

   atmega_btn_ctrl #(
      .CHANNELS        (8),
      .TICK_DIV        (T),
      .DB_SAMPLES      (DB),
      .ACTIVE_LOW_MASK (ALM),
      .REPEAT_DELAY    (D),
      .REPEAT_RATE     (R),
      .PIN_ADDR        (A_PIN),
      .IFR_ADDR        (A_IFR),
      .IMSK_ADDR       (A_IMSK),
      .RISE_ADDR       (A_RISE),
      .FALL_ADDR       (A_FALL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .btn_in    (btn_in),
      .btn_state (btn_state),
      .intr      (intr),
      .int_rst   (int_rst)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int         k = 0;             // index of the next clock edge
   int         r = 0;             // edge index of the last reset
   logic [7:0] hist[$];           // raw pin values still in flight to the logic
   logic [7:0] m_stable, m_ifr, m_imsk, m_rise, m_fall;
   int         diff_since[8];     // first edge of current disagreement, -1 if none
   int         press_edge[8];     // edge at which stable last became 1

   // Number of debounce ticks on edges a..b (ticks fall on edges r+T, r+2T, ...).
   function automatic int ticks_in(input int a, input int b);
      if (a > b) return 0;
      return (b - r) / T - (a - 1 - r) / T;
   endfunction

   task automatic model_edge();
      logic [7:0] s, set, clr, ack;
      int n;
      if (!rst_n) begin
         hist.delete();
         hist.push_back(ALM);
         hist.push_back(ALM);
         m_stable = '0; m_ifr = '0; m_imsk = '0; m_rise = 8'hFF; m_fall = '0;
         for (int ch = 0; ch < 8; ch++) begin
            diff_since[ch] = -1;
            press_edge[ch] = 0;
         end
         r = k;
      end else begin
         s   = hist[0] ^ ALM;
         set = '0;
         for (int ch = 0; ch < 8; ch++) begin
`ifdef BTN_CTRL_AUTOREPEAT_EN
            if (((k - r) % T == 0) && m_stable[ch] && m_rise[ch]) begin
               n = ticks_in(press_edge[ch] + 1, k);
               if (n >= D && ((n - D) % R) == 0) set[ch] = 1'b1;
            end
`endif
            if (s[ch] == m_stable[ch]) begin
               diff_since[ch] = -1;
            end else begin
               if (diff_since[ch] < 0) diff_since[ch] = k;
               if (((k - r) % T == 0) && ticks_in(diff_since[ch], k) == DB) begin
                  m_stable[ch]   = s[ch];
                  diff_since[ch] = -1;
                  if (s[ch]) begin
                     press_edge[ch] = k;
                     if (m_rise[ch]) set[ch] = 1'b1;
                  end else if (m_fall[ch]) begin
                     set[ch] = 1'b1;
                  end
               end
            end
         end
         clr   = (bus.wr && bus.addr == A_IFR) ? bus.bus_in : 8'h00;
         ack   = int_rst ? m_imsk : 8'h00;
         m_ifr = (m_ifr & ~clr & ~ack) | set;
         if (bus.wr && bus.addr == A_IMSK) m_imsk = bus.bus_in;
         if (bus.wr && bus.addr == A_RISE) m_rise = bus.bus_in;
         if (bus.wr && bus.addr == A_FALL) m_fall = bus.bus_in;
         void'(hist.pop_front());
         hist.push_back(btn_in);
      end
      k++;
   endtask

   // ---------------- bus helpers ----------------
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
      logic [7:0] save;
      save     = bus.addr;
      bus.addr = a;
      bus.rd   = 1'b1;
      #1;
      d        = bus.bus_out;
      bus.rd   = 1'b0;
      bus.addr = save;
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
      bus.addr   = a;
      bus.bus_in = d;
      bus.wr     = 1'b1;
      step();
      bus.wr     = 1'b0;
   endtask

   // Wait until btn_state masked by m equals v; returns cycles taken or -1.
   task automatic wait_state(input logic [7:0] m, input logic [7:0] v, output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         step();
         if ((btn_state & m) == v) begin
            lat = c;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [7:0] d;
      btn_in = 8'hFF; int_rst = 1'b0;
      bus.addr = 8'h00; bus.wr = 1'b0; bus.rd = 1'b0; bus.bus_in = 8'h00;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_cmp++; if (bus.bus_out !== 8'h00) begin n_bad++; $display("FAIL reset_bus_idle: got %h expected 00", bus.bus_out); end
      rd_reg(A_PIN, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_pin: got %h expected 00", d); end
      rd_reg(A_IFR, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_ifr: got %h expected 00", d); end
      rd_reg(A_RISE, d);
      n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL reset_rise: got %h expected ff", d); end
      rd_reg(A_FALL, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_fall: got %h expected 00", d); end
      n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL reset_intr: got %b expected 0", intr); end
      n_cmp++; if (btn_state !== 8'h00) begin n_bad++; $display("FAIL reset_state: got %h expected 00", btn_state); end
   endtask

   task automatic test_reset_mid_debounce();
      int lat;
      btn_in[3] = 1'b0;
      repeat (8) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_cmp++; if (btn_state[3] !== 1'b0) begin n_bad++; $display("FAIL midreset_cleared: got %b expected 0", btn_state[3]); end
      wait_state(8'h08, 8'h08, lat);
      n_cmp++; if (lat < 11 || lat > 14) begin n_bad++; $display("FAIL midreset_latency: got %0d expected 11..14", lat); end
      n_cmp++; if (btn_state !== m_stable) begin n_bad++; $display("FAIL midreset_model: got %h expected %h", btn_state, m_stable); end
      btn_in[3] = 1'b1;
      wait_state(8'h08, 8'h00, lat);
      n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL midreset_release: timeout expected release"); end
      wr_reg(A_IFR, 8'hFF);
      wr_reg(A_IMSK, 8'h01);
   endtask

   task automatic test_clean_press();
      int lat;
      logic [7:0] d;
      btn_in[0] = 1'b0;
      wait_state(8'h01, 8'h01, lat);
      n_cmp++; if (lat < 11 || lat > 14) begin n_bad++; $display("FAIL press_latency: got %0d expected 11..14", lat); end
      rd_reg(A_IFR, d);
      n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL press_ifr: got %h expected 01", d); end
      n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL press_intr: got %b expected 1", intr); end
      n_cmp++; if (btn_state !== m_stable) begin n_bad++; $display("FAIL press_model: got %h expected %h", btn_state, m_stable); end
   endtask

   task automatic test_bounce();
      logic [7:0] pin0, ifr0, d;
      logic       intr0;
      logic       ok;
      pin0 = m_stable; ifr0 = m_ifr; intr0 = |(m_ifr & m_imsk);
      ok = 1'b1;
      btn_in[1] = 1'b0;
      for (int c = 0; c < 46; c++) begin
         if (c == 6) btn_in[1] = 1'b1;
         step();
         rd_reg(A_PIN, d);
         n_cmp++; if (d !== pin0) begin n_bad++; $display("FAIL bounce_pin c=%0d: got %h expected %h", c, d, pin0); end
         rd_reg(A_IFR, d);
         n_cmp++; if (d !== ifr0) begin n_bad++; $display("FAIL bounce_ifr c=%0d: got %h expected %h", c, d, ifr0); end
         n_cmp++; if (intr !== intr0) begin n_bad++; $display("FAIL bounce_intr c=%0d: got %b expected %b", c, intr, intr0); end
      end
   endtask

   task automatic test_collision();
      int lat;
      logic [7:0] d;
      btn_in[0] = 1'b1;
      wait_state(8'h01, 8'h00, lat);
      n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL collide_release: timeout expected release"); end
      bus.addr = A_IFR; bus.bus_in = 8'h01; bus.wr = 1'b1;
      btn_in[0] = 1'b0;
      wait_state(8'h01, 8'h01, lat);
      n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL collide_press: timeout expected press"); end
      rd_reg(A_IFR, d);
      bus.wr = 1'b0;
      n_cmp++; if (d[0] !== 1'b1) begin n_bad++; $display("FAIL collide_set_wins: got %b expected 1", d[0]); end
      n_cmp++; if (d !== m_ifr) begin n_bad++; $display("FAIL collide_model: got %h expected %h", d, m_ifr); end
   endtask

   task automatic test_ack();
      int lat;
      logic [7:0] d;
      btn_in[2] = 1'b0;
      wait_state(8'h04, 8'h04, lat);
      n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL ack_press2: timeout expected press"); end
      btn_in[0] = 1'b1; btn_in[2] = 1'b1;
      wait_state(8'h05, 8'h00, lat);
      n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL ack_release: timeout expected release"); end
      wr_reg(A_IFR, 8'hFA);
      wr_reg(A_IMSK, 8'h01);
      rd_reg(A_IFR, d);
      n_cmp++; if (d !== 8'h05) begin n_bad++; $display("FAIL ack_before: got %h expected 05", d); end
      n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL ack_intr_before: got %b expected 1", intr); end
      int_rst = 1'b1;
      step();
      int_rst = 1'b0;
      rd_reg(A_IFR, d);
      n_cmp++; if (d !== 8'h04) begin n_bad++; $display("FAIL ack_after: got %h expected 04", d); end
      n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL ack_intr_after: got %b expected 0", intr); end
   endtask

   task automatic test_repeat();
      int lat;
      int rec[$];
      int exp_q[$];
      logic [7:0] d;
      logic pending;
`ifdef BTN_CTRL_AUTOREPEAT_EN
      exp_q = '{0, 4 * T, 6 * T, 8 * T};
`else
      exp_q = '{0};
`endif
      wr_reg(A_IFR, 8'hFF);
      btn_in[2] = 1'b0;
      wait_state(8'h04, 8'h04, lat);
      n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL repeat_press: timeout expected press"); end
      pending = 1'b0;
      rd_reg(A_IFR, d);
      if (d[2]) begin rec.push_back(0); pending = 1'b1; end
      for (int c = 1; c <= 34; c++) begin
         if (pending) begin bus.addr = A_IFR; bus.bus_in = 8'h04; bus.wr = 1'b1; end
         pending = 1'b0;
         step();
         bus.wr = 1'b0;
         rd_reg(A_IFR, d);
         if (d[2]) begin rec.push_back(c); pending = 1'b1; end
      end
      n_cmp++; if (rec.size() != exp_q.size()) begin n_bad++; $display("FAIL repeat_count: got %0d flags expected %0d", rec.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rec.size(); i++) begin
         n_cmp++; if (rec[i] != exp_q[i]) begin n_bad++; $display("FAIL repeat_time[%0d]: got cycle %0d expected %0d", i, rec[i], exp_q[i]); end
      end
      btn_in[2] = 1'b1;
      wait_state(8'h04, 8'h00, lat);
      n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL repeat_release: timeout expected release"); end
   endtask

   task automatic test_random();
      int hold[8];
      logic [7:0] d;
      for (int ch = 0; ch < 8; ch++) hold[ch] = $urandom_range(1, 20);
      wr_reg(A_FALL, 8'($urandom));
      wr_reg(A_IMSK, 8'($urandom));
      for (int c = 0; c < 1500; c++) begin
         for (int ch = 0; ch < 8; ch++) begin
            if (hold[ch] == 0) begin
               btn_in[ch] = ~btn_in[ch];
               hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 40);
            end else begin
               hold[ch]--;
            end
         end
         bus.wr = 1'b0;
         case ($urandom_range(0, 31))
            0, 1: begin bus.addr = A_IFR; bus.bus_in = 8'($urandom); bus.wr = 1'b1; end
            2:    begin bus.addr = A_PIN; bus.bus_in = 8'($urandom); bus.wr = 1'b1; end
            3:    begin bus.addr = A_IMSK; bus.bus_in = 8'($urandom); bus.wr = 1'b1; end
            default: ;
         endcase
         int_rst = ($urandom_range(0, 23) == 0);
         step();
         bus.wr = 1'b0; int_rst = 1'b0;
         n_cmp++; if (btn_state !== m_stable) begin n_bad++; $display("FAIL rnd_state c=%0d: got %h expected %h", c, btn_state, m_stable); end
         rd_reg(A_IFR, d);
         n_cmp++; if (d !== m_ifr) begin n_bad++; $display("FAIL rnd_ifr c=%0d: got %h expected %h", c, d, m_ifr); end
         n_cmp++; if (intr !== |(m_ifr & m_imsk)) begin n_bad++; $display("FAIL rnd_intr c=%0d: got %b expected %b", c, intr, |(m_ifr & m_imsk)); end
         if (c % 16 == 0) begin
            rd_reg(A_PIN, d);
            n_cmp++; if (d !== m_stable) begin n_bad++; $display("FAIL rnd_pin c=%0d: got %h expected %h", c, d, m_stable); end
            rd_reg(A_IMSK, d);
            n_cmp++; if (d !== m_imsk) begin n_bad++; $display("FAIL rnd_imsk c=%0d: got %h expected %h", c, d, m_imsk); end
            rd_reg(8'h30, d);
            n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rnd_unmapped c=%0d: got %h expected 00", c, d); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_debounce();
      test_clean_press();
      test_bounce();
      test_collision();
      test_ack();
      test_repeat();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
